// File: rtl/igr_wadj_mc_csr_intf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : igr_wadj_mc_csr_intf
// Description : Multi-channel AVMM CSR slave for the ingress width adjusters.
//               Per-channel config, saturating drop counter and sticky status.
// Revision    : 1.0 - initial release
// ============================================================================
module igr_wadj_mc_csr_intf #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned BASE_ADDR     = 'h0,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned THR_W         = 16,
    parameter logic [15:0] DEF_PAUSE_THR = 16'h0100,
    parameter logic [15:0] DEF_DROP_THR  = 16'h0200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     avmm_address,
    input  logic                      avmm_read,
    input  logic                      avmm_write,
    input  logic [DATA_WIDTH-1:0]     avmm_writedata,
    input  logic [3:0]                avmm_byteenable,
    output logic [DATA_WIDTH-1:0]     avmm_readdata,
    output logic                      avmm_readdata_valid,
    input  logic [NUM_CH-1:0]         drop_pulse,
    input  logic [NUM_CH-1:0]         pause_active,
    output logic [NUM_CH-1:0]         cfg_rx_pause_en,
    output logic [NUM_CH-1:0]         cfg_drop_en,
    output logic [NUM_CH*THR_W-1:0]   cfg_rx_pause_threshold,
    output logic [NUM_CH*THR_W-1:0]   cfg_drop_threshold
);

    localparam int unsigned           c_chw      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH:0]   c_base     = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   c_span     = (ADDR_WIDTH+1)'(4*NUM_CH);
    localparam logic [31:0]           c_cnt_max  = 32'hFFFF_FFFF;
    localparam logic [31:0]           c_cnt_near = 32'hFFFF_FFFE;
    localparam logic [THR_W-1:0]      c_def_pause = DEF_PAUSE_THR[THR_W-1:0];
    localparam logic [THR_W-1:0]      c_def_drop  = DEF_DROP_THR[THR_W-1:0];

    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic                  r_s1_rd;
    logic                  r_s1_wr;
    logic [31:0]           r_s1_wdata;
    logic [3:0]            r_s1_be;
    logic [31:0]           r_rdata;
    logic                  r_rvalid;

    logic [ADDR_WIDTH:0]   w_rel;
    logic                  w_in_range;
    logic [1:0]            w_off;
    logic [c_chw-1:0]      w_ch;
    logic [31:0]           w_bmask;
    logic [31:0]           w_rdata;
    logic [31:0]           w_ch_rdata [NUM_CH];

    // Stage 1: capture the request; a simultaneous write is dropped in favour of the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_addr  <= '0;
            r_s1_rd    <= 1'b0;
            r_s1_wr    <= 1'b0;
            r_s1_wdata <= '0;
            r_s1_be    <= '0;
        end else begin
            r_s1_addr  <= avmm_address;
            r_s1_rd    <= avmm_read;
            r_s1_wr    <= avmm_write & ~avmm_read;
            r_s1_wdata <= 32'(avmm_writedata);
            r_s1_be    <= avmm_byteenable;
        end
    end

    // Extra MSB on the relative address catches addresses below the base.
    assign w_rel      = {1'b0, r_s1_addr} - c_base;
    assign w_in_range = ~w_rel[ADDR_WIDTH] && (w_rel < c_span);
    assign w_off      = w_rel[1:0];
    assign w_ch       = w_rel[c_chw+1:2];
    assign w_rdata    = w_in_range ? w_ch_rdata[w_ch] : 32'h0;

    for (genvar i = 0; i < 4; i++) begin : g_mask
        assign w_bmask[i*8 +: 8] = {8{r_s1_be[i]}};
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              r_pause_en;
        logic              r_drop_en;
        logic [THR_W-1:0]  r_pause_thr;
        logic [THR_W-1:0]  r_drop_thr;
        logic [31:0]       r_dropcnt;
        logic              r_st_pause;
        logic              r_st_sat;
        logic              w_hit;
        logic              w_clr;
        logic              w_wr_ctl;
        logic              w_wr_thr;
        logic              w_w1c_pause;
        logic              w_w1c_sat;
        logic              w_sat_set;
        logic [31:0]       w_thr_word;

        assign w_hit       = w_in_range && (w_ch == c_chw'(c));
        assign w_clr       = r_s1_rd && w_hit && (w_off == 2'd2);
        assign w_wr_ctl    = r_s1_wr && w_hit && (w_off == 2'd0) && r_s1_be[0];
        assign w_wr_thr    = r_s1_wr && w_hit && (w_off == 2'd1);
        assign w_w1c_pause = r_s1_wr && w_hit && (w_off == 2'd3) && r_s1_be[0] && r_s1_wdata[0];
        assign w_w1c_sat   = r_s1_wr && w_hit && (w_off == 2'd3) && r_s1_be[1] && r_s1_wdata[8];
        // A pulse that lands the count on all-ones (or finds it there) flags saturation.
        assign w_sat_set   = drop_pulse[c] && !w_clr && (r_dropcnt >= c_cnt_near);
        assign w_thr_word  = {16'(r_drop_thr), 16'(r_pause_thr)};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pause_en  <= 1'b0;
                r_drop_en   <= 1'b1;
                r_pause_thr <= c_def_pause;
                r_drop_thr  <= c_def_drop;
                r_dropcnt   <= '0;
                r_st_pause  <= 1'b0;
                r_st_sat    <= 1'b0;
            end else begin
                if (w_wr_ctl) begin
                    r_pause_en <= r_s1_wdata[0];
                    r_drop_en  <= r_s1_wdata[1];
                end
                if (w_wr_thr) begin
                    r_pause_thr <= (r_pause_thr & ~w_bmask[THR_W-1:0])
                                 | (r_s1_wdata[THR_W-1:0] & w_bmask[THR_W-1:0]);
                    r_drop_thr  <= (r_drop_thr & ~w_bmask[16 +: THR_W])
                                 | (r_s1_wdata[16 +: THR_W] & w_bmask[16 +: THR_W]);
                end
                if (w_clr) begin
                    r_dropcnt <= {31'h0, drop_pulse[c]};
                end else if (drop_pulse[c] && (r_dropcnt != c_cnt_max)) begin
                    r_dropcnt <= r_dropcnt + 32'h1;
                end
                r_st_pause <= pause_active[c] | (r_st_pause & ~w_w1c_pause);
                r_st_sat   <= w_sat_set | (r_st_sat & ~w_w1c_sat);
            end
        end

        assign w_ch_rdata[c] = (w_off == 2'd0) ? {30'h0, r_drop_en, r_pause_en} :
                               (w_off == 2'd1) ? w_thr_word :
                               (w_off == 2'd2) ? r_dropcnt :
                                                 {23'h0, r_st_sat, 7'h0, r_st_pause};

        assign cfg_rx_pause_en[c]                   = r_pause_en;
        assign cfg_drop_en[c]                       = r_drop_en;
        assign cfg_rx_pause_threshold[c*THR_W +: THR_W] = r_pause_thr;
        assign cfg_drop_threshold[c*THR_W +: THR_W]     = r_drop_thr;
    end

    // Stage 2 output register; out-of-range reads still return a valid zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= r_s1_rd;
            r_rdata  <= r_s1_rd ? w_rdata : 32'h0;
        end
    end

    assign avmm_readdata       = DATA_WIDTH'(r_rdata);
    assign avmm_readdata_valid = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_igr_wadj_mc_csr_intf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_igr_wadj_mc_csr_intf
// Description : Directed plus randomized bench with a register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_igr_wadj_mc_csr_intf;

    localparam int NCH  = 4;
    localparam int BASE = 'h20;
    localparam int AW   = 8;
    localparam int TW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   avmm_address = '0;
    logic            avmm_read = 1'b0;
    logic            avmm_write = 1'b0;
    logic [31:0]     avmm_writedata = '0;
    logic [3:0]      avmm_byteenable = '0;
    logic [31:0]     avmm_readdata;
    logic            avmm_readdata_valid;
    logic [NCH-1:0]  drop_pulse = '0;
    logic [NCH-1:0]  pause_active = '0;
    logic [NCH-1:0]  cfg_rx_pause_en;
    logic [NCH-1:0]  cfg_drop_en;
    logic [NCH*TW-1:0] cfg_rx_pause_threshold;
    logic [NCH*TW-1:0] cfg_drop_threshold;

    int checks = 0;
    int errors = 0;

    igr_wadj_mc_csr_intf #(
        .NUM_CH(NCH), .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .THR_W(TW),
        .DEF_PAUSE_THR(16'h0100), .DEF_DROP_THR(16'h0200)
    ) dut (
        .clk(clk), .rst(rst),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_readdata(avmm_readdata), .avmm_readdata_valid(avmm_readdata_valid),
        .drop_pulse(drop_pulse), .pause_active(pause_active),
        .cfg_rx_pause_en(cfg_rx_pause_en), .cfg_drop_en(cfg_drop_en),
        .cfg_rx_pause_threshold(cfg_rx_pause_threshold), .cfg_drop_threshold(cfg_drop_threshold)
    );

    always #5 clk = ~clk;

    // Register-map model: a request issued in cycle N takes effect one cycle later
    // and its read result is visible from cycle N+2.
    bit          m_pen [NCH];
    bit          m_den [NCH];
    logic [15:0] m_pthr[NCH];
    logic [15:0] m_dthr[NCH];
    logic [31:0] m_cnt [NCH];
    bit          m_stp [NCH];
    bit          m_sts [NCH];
    bit          p_rd, p_wr;
    int          p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_be;
    bit          e_valid;
    logic [31:0] e_data;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pen[c] = 0; m_den[c] = 1; m_pthr[c] = 16'h0100; m_dthr[c] = 16'h0200;
            m_cnt[c] = 0; m_stp[c] = 0; m_sts[c] = 0;
        end
        p_rd = 0; p_wr = 0; p_addr = 0; p_data = 0; p_be = 0;
        e_valid = 0; e_data = 0;
    endtask

    function automatic logic [31:0] model_read(int ch, int off);
        case (off)
            0: return {30'h0, m_den[ch], m_pen[ch]};
            1: return {m_dthr[ch], m_pthr[ch]};
            2: return m_cnt[ch];
            default: return {23'h0, m_sts[ch], 7'h0, m_stp[ch]};
        endcase
    endfunction

    task automatic model_step();
        bit hit;
        int ch, off;
        hit = (p_addr >= BASE) && (p_addr < BASE + 4*NCH);
        ch  = (p_addr - BASE) / 4;
        off = (p_addr - BASE) % 4;
        e_valid = p_rd;
        e_data  = (p_rd && hit) ? model_read(ch, off) : 32'h0;
        if (p_wr && hit) begin
            case (off)
                0: if (p_be[0]) begin m_pen[ch] = p_data[0]; m_den[ch] = p_data[1]; end
                1: for (int k = 0; k < 2; k++) begin
                       if (p_be[k])   m_pthr[ch][8*k +: 8] = p_data[8*k +: 8];
                       if (p_be[k+2]) m_dthr[ch][8*k +: 8] = p_data[16 + 8*k +: 8];
                   end
                3: begin
                       if (p_be[0] && p_data[0]) m_stp[ch] = 0;
                       if (p_be[1] && p_data[8]) m_sts[ch] = 0;
                   end
                default: ;
            endcase
        end
        for (int c = 0; c < NCH; c++) begin
            if (p_rd && hit && ch == c && off == 2) begin
                m_cnt[c] = drop_pulse[c] ? 32'd1 : 32'd0;
            end else if (drop_pulse[c] && m_cnt[c] != 32'hFFFF_FFFF) begin
                m_cnt[c] = m_cnt[c] + 1;
                if (m_cnt[c] == 32'hFFFF_FFFF) m_sts[c] = 1;
            end else if (drop_pulse[c]) begin
                m_sts[c] = 1;
            end
            if (pause_active[c]) m_stp[c] = 1;
        end
        p_rd = avmm_read; p_wr = avmm_write && !avmm_read; p_addr = int'(avmm_address);
        p_data = avmm_writedata; p_be = avmm_byteenable;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, clear of the clock edges.
    initial begin
        logic [63:0] ep, ed;
        logic [3:0]  epe, ede;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int c = 0; c < NCH; c++) begin
                    ep[c*16 +: 16] = m_pthr[c]; ed[c*16 +: 16] = m_dthr[c];
                    epe[c] = m_pen[c];          ede[c] = m_den[c];
                end
                chk("model valid", 64'(avmm_readdata_valid), 64'(e_valid));
                if (e_valid) chk("model rdata", 64'(avmm_readdata), 64'(e_data));
                chk("model pause_en", 64'(cfg_rx_pause_en), 64'(epe));
                chk("model drop_en", 64'(cfg_drop_en), 64'(ede));
                chk("model pause_thr", cfg_rx_pause_threshold, ep);
                chk("model drop_thr", cfg_drop_threshold, ed);
            end
        end
    end

    task automatic rd(input int addr, input logic [31:0] exp, input string nm, input bit pulse1 = 0);
        @(negedge clk); avmm_address = AW'(addr); avmm_read = 1'b1;
        @(negedge clk); avmm_read = 1'b0; if (pulse1) drop_pulse[1] = 1'b1;
        chk({nm, " valid N+1"}, 64'(avmm_readdata_valid), 64'd0);
        @(negedge clk); drop_pulse[1] = 1'b0;
        chk({nm, " valid N+2"}, 64'(avmm_readdata_valid), 64'd1);
        chk(nm, 64'(avmm_readdata), 64'(exp));
    endtask

    task automatic wr(input int addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk); avmm_address = AW'(addr); avmm_writedata = data;
        avmm_byteenable = be; avmm_write = 1'b1;
        @(negedge clk); avmm_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset valid", 64'(avmm_readdata_valid), 64'd0);
        chk("reset cfg drop_en", 64'(cfg_drop_en), 64'hF);

        rd(BASE + 0, 32'h0000_0002, "ch0 control");
        rd(BASE + 1, 32'h0200_0100, "ch0 thresh");

        wr(BASE + 9, 32'h0400_0080, 4'b0011);
        chk("be write pause_thr", cfg_rx_pause_threshold, 64'h0100_0080_0100_0100);
        chk("be write drop_thr", cfg_drop_threshold, 64'h0200_0200_0200_0200);
        rd(BASE + 9, 32'h0200_0080, "ch2 thresh");

        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drop_pulse[1] = 1'b1;
        end
        @(negedge clk); drop_pulse[1] = 1'b0;
        rd(BASE + 6, 32'd5, "dropcnt five");
        rd(BASE + 6, 32'd0, "dropcnt cleared", 1'b1);
        rd(BASE + 6, 32'd1, "dropcnt pulse during clear");

        @(negedge clk);
        dut.g_ch[1].r_dropcnt = 32'hFFFF_FFFC;
        m_cnt[1] = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drop_pulse[1] = 1'b1;
        end
        @(negedge clk); drop_pulse[1] = 1'b0;
        rd(BASE + 7, 32'h0000_0100, "status saturated");
        rd(BASE + 6, 32'hFFFF_FFFF, "dropcnt saturated");
        wr(BASE + 7, 32'h0000_0100, 4'hF);
        rd(BASE + 7, 32'h0, "status sat w1c");

        @(negedge clk); pause_active[3] = 1'b1;
        @(negedge clk); pause_active[3] = 1'b0;
        rd(BASE + 15, 32'h1, "status pause seen");
        pause_active[3] = 1'b1;
        wr(BASE + 15, 32'h1, 4'hF);
        pause_active[3] = 1'b0;
        rd(BASE + 15, 32'h1, "status set beats w1c");
        wr(BASE + 15, 32'h1, 4'hF);
        rd(BASE + 15, 32'h0, "status pause w1c");

        rd(BASE + 4*NCH, 32'h0, "out of range read");
        rd(BASE - 1, 32'h0, "below range read");
        wr(BASE + 4*NCH, 32'hFFFF_FFFF, 4'hF);
        wr(BASE - 4, 32'hFFFF_FFFF, 4'hF);
        chk("oor write pause_thr", cfg_rx_pause_threshold, 64'h0100_0080_0100_0100);
        chk("oor write enables", 64'({cfg_drop_en, cfg_rx_pause_en}), 64'hF0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 9);
            avmm_address    = AW'($urandom_range(BASE - 3, BASE + 4*NCH + 2));
            avmm_read       = (r < 4);
            avmm_write      = (r >= 3 && r < 7);
            avmm_writedata  = $urandom;
            avmm_byteenable = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                drop_pulse[c]   = ($urandom_range(0, 3) == 0);
                pause_active[c] = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clk);
        avmm_read = 1'b0; avmm_write = 1'b0; drop_pulse = '0; pause_active = '0;
        repeat (3) @(negedge clk);

        avmm_address = AW'(BASE + 1); avmm_read = 1'b1;
        @(negedge clk); avmm_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst mid-read valid", 64'(avmm_readdata_valid), 64'd0);
        chk("rst pause_en", 64'(cfg_rx_pause_en), 64'd0);
        chk("rst drop_en", 64'(cfg_drop_en), 64'hF);
        chk("rst pause_thr", cfg_rx_pause_threshold, 64'h0100_0100_0100_0100);
        chk("rst drop_thr", cfg_drop_threshold, 64'h0200_0200_0200_0200);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst valid", 64'(avmm_readdata_valid), 64'd0);
        rd(BASE + 6, 32'h0, "post-rst dropcnt");
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
